// File: rtl/fft_frame_serializer_pkg.sv
// Shared types and constants for the FFT input serializer path.
package fft_frame_serializer_pkg;

    localparam int FFT_N     = 8;
    localparam int FFT_LOG2N = $clog2(FFT_N);
    localparam int SAMPLE_W  = 16;

    // One complex sample as produced by the subcarrier mapper.
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } complex_product_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } ser_state_t;

    // Bit-reversed sample index, for a natural-order output variant.
    function automatic logic [FFT_LOG2N-1:0] bit_reverse(input logic [FFT_LOG2N-1:0] idx);
        logic [FFT_LOG2N-1:0] rev;
        rev = '0;
        for (int b = 0; b < FFT_LOG2N; b++) begin
            rev[b] = idx[FFT_LOG2N-1-b];
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_frame_serializer_buffer.sv
// Two-slot ping-pong frame store with occupancy tracking and a DIF pair-read port.
module pingpong_frame_buffer
    import fft_frame_serializer_pkg::*;
#(
    parameter int N  = FFT_N,
    parameter int KW = $clog2(N/2)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  complex_product_t [N-1:0]  frame_in,
    input  logic                      pop,
    input  logic [KW-1:0]             k,
    output logic                      in_ready,
    output logic [1:0]                count,
    output logic                      more,
    output complex_product_t          pair_0,
    output complex_product_t          pair_1
);

    logic                     wr_sel;
    logic                     rd_sel;
    logic                     push;
    logic [1:0]               count_next;
    complex_product_t [N-1:0] rd_frame;

    // Ready depends only on registered occupancy; a same-cycle drain does not help.
    assign in_ready = (count != 2'd2);
    assign push     = in_valid && in_ready;

    // Occupancy after this edge; accept plus release leaves it unchanged.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Tells the sequencer whether a frame remains once this edge completes.
    assign more = (count_next != 2'd0);

    // Slot pointers and occupancy; reset discards whatever is buffered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            count <= count_next;
            if (push) wr_sel <= ~wr_sel;
            if (pop)  rd_sel <= ~rd_sel;
        end
    end

    // One storage register per slot; a whole frame is captured in one edge.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            complex_product_t [N-1:0] frame_q;

            // Capture the frame when this slot is the write target.
            always_ff @(posedge clk) begin
                if (push && (wr_sel == 1'(gi))) frame_q <= frame_in;
            end
        end
    endgenerate

    assign rd_frame = rd_sel ? g_slot[1].frame_q : g_slot[0].frame_q;

    // DIF pairing: k with k+N/2, i.e. the top index bit selects the half.
    assign pair_0 = rd_frame[{1'b0, k}];
    assign pair_1 = rd_frame[{1'b1, k}];

endmodule

// File: rtl/fft_frame_serializer.sv
// Serializes buffered parallel frames into two-samples-per-cycle FFT input pairs.
module fft_frame_serializer
    import fft_frame_serializer_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int PAIRS = N/2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  complex_product_t [N-1:0]  frame_in,
    input  logic                      hold,
    output complex_product_t          data_0,
    output complex_product_t          data_1,
    output logic                      out_valid,
    output logic                      frame_start,
    output logic                      frame_last
);

    localparam int KW = $clog2(PAIRS);

    ser_state_t       state;
    logic [KW-1:0]    k;
    logic [1:0]       count;
    logic             more;
    logic             emit;
    logic             last_pair;
    logic             pop;
    complex_product_t pair_0;
    complex_product_t pair_1;

    assign last_pair = (k == KW'(PAIRS-1));

    // A pair goes out on any unheld edge while a frame is available.
    always_comb begin
        emit = 1'b0;
        case (state)
            ST_IDLE:   emit = !hold && (count != 2'd0);
            ST_STREAM: emit = !hold;
            default:   emit = 1'b0;
        endcase
    end

    // The slot is released on the same edge that emits its last pair.
    assign pop = emit && last_pair;

    pingpong_frame_buffer #(
        .N  (N),
        .KW (KW)
    ) u_buffer (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .frame_in (frame_in),
        .pop      (pop),
        .k        (k),
        .in_ready (in_ready),
        .count    (count),
        .more     (more),
        .pair_0   (pair_0),
        .pair_1   (pair_1)
    );

    // Sequencer: pair counter, state and registered stream outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            k           <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            data_0      <= '0;
            data_1      <= '0;
        end else begin
            out_valid   <= emit;
            frame_start <= emit && (k == '0);
            frame_last  <= pop;
            if (emit) begin
                data_0 <= pair_0;
                data_1 <= pair_1;
                k      <= last_pair ? '0 : k + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (emit) state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (pop && !more) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Self-checking bench: cycle table, directed corner sequences and random traffic
// compared against a frame-queue reference model.
module tb_fft_frame_serializer;
    import fft_frame_serializer_pkg::*;

    localparam int N     = 8;
    localparam int PAIRS = N/2;

    typedef complex_product_t [N-1:0] frame_t;

    typedef struct {
        complex_product_t d0;
        complex_product_t d1;
        logic             start;
        logic             last;
    } pair_t;

    typedef struct {
        logic iv;
        logic ev;
        int   re0;
        int   re1;
        logic st;
        logic la;
        logic rdy;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    frame_t           frame_in;
    logic             hold;
    complex_product_t data_0;
    complex_product_t data_1;
    logic             out_valid;
    logic             frame_start;
    logic             frame_last;

    int    vectors     = 0;
    int    miscompares = 0;
    pair_t exp_q[$];
    int    accepted    = 0;
    int    completed   = 0;
    logic  last_acc;

    vec_t   tbl[6];
    frame_t bb[3];
    frame_t zero_frame;

    fft_frame_serializer #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .frame_in    (frame_in),
        .hold        (hold),
        .data_0      (data_0),
        .data_1      (data_1),
        .out_valid   (out_valid),
        .frame_start (frame_start),
        .frame_last  (frame_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic frame_t make_frame(input int base);
        frame_t f;
        for (int i = 0; i < N; i++) begin
            f[i].re = 16'(base + i + 1);
            f[i].im = 16'(-(base + i + 1));
        end
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < N; i++) begin
            f[i].re = 16'($urandom);
            f[i].im = 16'($urandom);
        end
        return f;
    endfunction

    // Reference: an accepted frame contributes PAIRS pairs (k, k+N/2) in order.
    task automatic model_accept(input frame_t f);
        pair_t p;
        for (int j = 0; j < PAIRS; j++) begin
            p.d0    = f[j];
            p.d1    = f[j + PAIRS];
            p.start = (j == 0);
            p.last  = (j == PAIRS - 1);
            exp_q.push_back(p);
        end
        accepted++;
    endtask

    // One clock: drive at the falling edge, observe at the next falling edge.
    task automatic step(input logic iv, input frame_t f, input logic h);
        pair_t p;
        logic  emit_exp;
        in_valid = iv;
        frame_in = f;
        hold     = h;
        last_acc = iv && in_ready;
        emit_exp = !h && (exp_q.size() > 0);
        if (last_acc) model_accept(f);
        @(posedge clk);
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(emit_exp));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_pair", 32'(out_valid), 32'd0);
            end else begin
                p = exp_q.pop_front();
                check("data_0", data_0, p.d0);
                check("data_1", data_1, p.d1);
                check("frame_start", 32'(frame_start), 32'(p.start));
                check("frame_last", 32'(frame_last), 32'(p.last));
                if (p.last) completed++;
            end
        end else begin
            check("idle_flags", {30'd0, frame_start, frame_last}, 32'd0);
        end
        check("in_ready", 32'(in_ready), 32'((accepted - completed) != 2));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, zero_frame, 1'b0);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Step until data_0.re shows the given value; bounded.
    task automatic run_until_re(input int re, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, zero_frame, 1'b0);
            if (out_valid && (32'(data_0.re) == 32'(re))) begin
                found = 1'b1;
                break;
            end
        end
        check(name, 32'(found), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nacc, first_v, last_v, nvalid, first_last, c_acc;
        logic saw_not_ready;

        zero_frame = '0;
        tbl[0] = '{iv: 1'b1, ev: 1'b0, re0: 0, re1: 0, st: 1'b0, la: 1'b0, rdy: 1'b1};
        tbl[1] = '{iv: 1'b0, ev: 1'b1, re0: 1, re1: 5, st: 1'b1, la: 1'b0, rdy: 1'b1};
        tbl[2] = '{iv: 1'b0, ev: 1'b1, re0: 2, re1: 6, st: 1'b0, la: 1'b0, rdy: 1'b1};
        tbl[3] = '{iv: 1'b0, ev: 1'b1, re0: 3, re1: 7, st: 1'b0, la: 1'b0, rdy: 1'b1};
        tbl[4] = '{iv: 1'b0, ev: 1'b1, re0: 4, re1: 8, st: 1'b0, la: 1'b1, rdy: 1'b1};
        tbl[5] = '{iv: 1'b0, ev: 1'b0, re0: 0, re1: 0, st: 1'b0, la: 1'b0, rdy: 1'b1};

        reset    = 1'b1;
        in_valid = 1'b0;
        hold     = 1'b0;
        frame_in = '0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", {30'd0, frame_start, frame_last}, 32'd0);
        check("rst_data_0", data_0, 32'd0);
        check("rst_data_1", data_1, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Single frame against the cycle table.
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].iv, make_frame(0), 1'b0);
            check("tbl_valid", 32'(out_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                check("tbl_re0", 32'(data_0.re), 32'(tbl[i].re0));
                check("tbl_re1", 32'(data_1.re), 32'(tbl[i].re1));
                check("tbl_im0", 32'(data_0.im), 32'(-tbl[i].re0));
                check("tbl_start", 32'(frame_start), 32'(tbl[i].st));
                check("tbl_last", 32'(frame_last), 32'(tbl[i].la));
            end
            check("tbl_ready", 32'(in_ready), 32'(tbl[i].rdy));
        end

        // Back-to-back: three frames offered continuously.
        bb[0] = make_frame(10 - 10);
        bb[1] = make_frame(10);
        bb[2] = make_frame(20);
        nacc = 0; first_v = -1; last_v = -1; nvalid = 0; first_last = -1; c_acc = -1;
        saw_not_ready = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (nacc < 3) begin
                step(1'b1, bb[nacc], 1'b0);
                if (last_acc) begin
                    if (nacc == 2) c_acc = cyc;
                    nacc++;
                end
            end else begin
                step(1'b0, zero_frame, 1'b0);
            end
            if (out_valid) begin
                nvalid++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (frame_last && first_last < 0) first_last = cyc;
            if (!in_ready) saw_not_ready = 1'b1;
        end
        check("bb_accepted", 32'(nacc), 32'd3);
        check("bb_valid_cycles", 32'(nvalid), 32'd12);
        check("bb_contiguous", 32'(last_v - first_v + 1), 32'd12);
        check("bb_c_after_release", 32'(c_acc > first_last), 32'd1);
        check("bb_saw_full", 32'(saw_not_ready), 32'd1);

        // Hold for three cycles after pair 1.
        step(1'b1, make_frame(30), 1'b0);
        step(1'b0, zero_frame, 1'b0);
        step(1'b0, zero_frame, 1'b0);
        check("hold_pair1", 32'(data_0.re), 32'd32);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, zero_frame, 1'b1);
            check("hold_quiet", 32'(out_valid), 32'd0);
        end
        step(1'b0, zero_frame, 1'b0);
        check("hold_resume_re0", 32'(data_0.re), 32'd33);
        check("hold_resume_re1", 32'(data_1.re), 32'd37);
        drain(6);

        // Full buffer: extra input must be ignored.
        step(1'b1, make_frame(40), 1'b1);
        step(1'b1, make_frame(50), 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("full_not_ready", 32'(in_ready), 32'd0);
            step(1'b1, make_frame(90), 1'b1);
        end
        drain(12);

        // Accept on the same edge as the release of the only buffered frame.
        step(1'b1, make_frame(60), 1'b0);
        run_until_re(63, "sim_reach_pair2");
        step(1'b1, make_frame(70), 1'b0);
        check("sim_last", 32'(frame_last), 32'd1);
        check("sim_ready", 32'(in_ready), 32'd1);
        step(1'b0, zero_frame, 1'b0);
        check("sim_no_gap", 32'(out_valid), 32'd1);
        check("sim_start", 32'(frame_start), 32'd1);
        check("sim_re0", 32'(data_0.re), 32'd71);
        drain(8);

        // Reset in the middle of a frame.
        step(1'b1, make_frame(80), 1'b0);
        run_until_re(83, "rst_reach_pair2");
        #2 reset = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_flags", {30'd0, frame_start, frame_last}, 32'd0);
        check("midrst_data", {data_0.re, data_1.re}, 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        accepted  = 0;
        completed = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, zero_frame, 1'b0);
        step(1'b1, make_frame(100), 1'b0);
        step(1'b0, zero_frame, 1'b0);
        check("postrst_start", 32'(frame_start), 32'd1);
        check("postrst_re0", 32'(data_0.re), 32'd101);
        drain(6);

        // Random traffic with random hold.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), rand_frame(), ($urandom_range(0, 3) == 0));
        end
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_frame_serializer.md
# fft_frame_serializer

Converts one parallel frame of `N` complex samples into the two-samples-per-cycle stream consumed by the radix-2 pipelined FFT/IFFT input (`data_0`/`data_1`/`enable`). It is the counterpart of the FFT's deserializer and reorder output stage. It sits between the subcarrier mapper, which produces whole frames, and the pipelined transform. A two-frame ping-pong buffer allows back-to-back frames with no idle cycles between them.

## Interface
- `N`, 8: frame length; power of two, ≥ 4.
- `PAIRS`, `N/2`: pairs emitted per frame (derived; do not override).
- `clk`  input  1  clock; all logic on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  `frame_in` holds a complete frame.
- `in_ready`  output  1  a buffer slot is free; a frame is accepted on `in_valid && in_ready`.
- `frame_in[N-1:0]`  input  `N` × `complex_product_t`  parallel frame, natural order.
- `hold`  input  1  pauses emission; the stream freezes in place.
- `data_0`  output  `complex_product_t`  upper butterfly input.
- `data_1`  output  `complex_product_t`  lower butterfly input.
- `out_valid`  output  1  pair valid; drives the transform's `enable`.
- `frame_start`  output  1  with the first pair of a frame.
- `frame_last`  output  1  with the last pair of a frame.

## Operation
- Storage: two frame slots. Write pointer `wr_sel`, read pointer `rd_sel`, occupancy `count` (0..2).
- `in_ready = (count != 2)`. It is a pure function of registered state, with no lookahead on a same-cycle drain.
- Accept: the whole `frame_in` is latched into slot `wr_sel`, then `wr_sel` toggles.
- Emission order (DIF pairing): for pair index `k` = 0..PAIRS-1, `data_0 = slot[k]` and `data_1 = slot[k+N/2]`.
- FSM:
  - IDLE: `out_valid` = 0. Moves to STREAM when `count > 0` and `hold` = 0.
  - STREAM: emits pair `k` each cycle in which `hold` = 0.
  - At `k = PAIRS-1`: the slot is released, `rd_sel` toggles and `k` returns to 0. The FSM stays in STREAM if another frame is buffered, otherwise it returns to IDLE.
- `hold` = 1: on the next edge `out_valid` = 0 and `k` keeps its value. Accepting a frame is still allowed while `hold` = 1.
- Accept and release in the same cycle: `count` is unchanged, and both pointers advance.
- Input when full: while `count` = 2, `in_valid` is ignored and nothing is overwritten.
- Reset, including mid-frame: any partial frame is discarded. `count`, pointers and `k` return to 0, and the FSM returns to IDLE.
- Data passes through unmodified: no scaling or rounding, and width equals `$bits(complex_product_t)`.

## Timing
- Reset values: `out_valid`, `frame_start` and `frame_last` are 0, `data_0` and `data_1` are 0, and `in_ready` is 1.
- All stream outputs are registered.
- Latency: a frame accepted at edge t into an empty block gives its first pair at t+1. This requires `hold` = 0.
- A frame occupies PAIRS valid cycles (4 for N = 8).
- Consecutive buffered frames are emitted with zero gap. `frame_last` of frame j and `frame_start` of frame j+1 fall on adjacent cycles.
- After a release from `count` = 2, `in_ready` rises on the following cycle.
- Sustained throughput is one frame per PAIRS cycles.
- `frame_start` and `frame_last` are asserted only while `out_valid` = 1.

## Structure
- `complex_product_t` comes from the shared package.
- Add to the shared package: `FFT_N`, and the bit-reverse helper function. The helper is needed if a natural-order variant is added later.
- Sub-module `pingpong_frame_buffer`: holds the two slots and the `wr_sel`/`rd_sel`/`count` logic, with a pair-read port indexed by `k`.
- The top level holds the FSM, the `k` counter, the output registers and the `hold` handling.

## Test plan
- Single frame: after reset, one frame with `frame_in[i].real = i+1`, imaginary parts = −(i+1), and `hold` = 0.
  - Required: `out_valid` 1 for exactly 4 cycles starting at t+1.
  - Real pairs are (1,5), (2,6), (3,7), (4,8).
  - `frame_start` is set on cycle 1 and `frame_last` on cycle 4.
- Back-to-back: three frames offered continuously, real values 1–8, 11–18 and 21–28.
  - Required: 12 contiguous valid cycles, with frame C accepted only after the first release.
  - `in_ready` is 0 while `count` = 2.
  - No frame is lost or duplicated.
- Hold: `hold` = 1 for 3 cycles after pair 1 of a frame.
  - Required: `out_valid` is 0 for those 3 cycles.
  - The sequence then resumes at pair 2 (3,7) and keeps its original order.
- Full buffer: `count` = 2 and `in_valid` held at 1 with different data.
  - Required: no accept.
  - The buffered frames are emitted intact.
- Simultaneous accept/release: a new frame is offered on the same cycle as `frame_last` with `count` = 1.
  - Required: `count` stays 1.
  - The new frame streams immediately after the current one with no gap.
- Reset mid-frame: `reset` asserted after pair 2.
  - Required: outputs are 0 immediately, `in_ready` is 1, and no stale pairs appear after release.
  - The next accepted frame starts at pair 0.
